// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rsp_valid;
  logic [INST_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding and
// feeds the IF/ID register, with a one-entry skid for responses landing during stall.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  PCSel,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  input  logic                  IF_flush,
  fetch_unit_if.master          imem,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_instr
);

  localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h00000013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN   = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_valid_q, req_valid_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [INST_WIDTH-1:0] skid_instr_q, skid_instr_d;

  logic redirect;
  logic req_fire;

  assign redirect = PCSel | IF_flush;
  assign req_fire = req_valid_q & imem.req_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = stall ? if_valid_q : 1'b0;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_instr_d = skid_instr_q;

    unique case (state_q)
      REQ: if (req_fire) state_d = WAIT;
      WAIT: begin
        if (imem.rsp_valid) begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem.rsp_data;
            pc_d       = pc_q + PC_STEP;
            state_d    = REQ;
          end else begin
            // The skid only needs the word: pc does not advance until it drains.
            skid_instr_d = imem.rsp_data;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = skid_instr_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = REQ;
        end
      end
      DROP: if (imem.rsp_valid) state_d = REQ;
      default: state_d = REQ;
    endcase

    // A redirect overrides any delivery this cycle and beats stall on IF/ID.
    if (redirect) begin
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      pc_d       = PCSel ? (pc_target & ALIGN) : pc_q;
      unique case (state_q)
        REQ:        state_d = req_fire ? DROP : REQ;
        WAIT, DROP: state_d = imem.rsp_valid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end

    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
  end

  assign imem.req_valid = req_valid_q;
  assign imem.addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model plus a program-order scoreboard of expected
// {pc, instr} deliveries, directed scenarios followed by randomized traffic.
module tb_fetch_unit;
  localparam int          AW       = 32;
  localparam int          IW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          PCSel;
  logic [AW-1:0] pc_target;
  logic          IF_flush;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_instr;

  fetch_unit_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) imem_bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .PCSel     (PCSel),
    .pc_target (pc_target),
    .IF_flush  (IF_flush),
    .imem      (imem_bus),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks    = 0;
  int          passed    = 0;
  int          delivered = 0;
  logic [31:0] last_pc   = 32'hFFFF_FFFF;
  exp_t        exp_q[$];
  logic [31:0] seq_pc;

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          rand_ready = 1'b0;
  bit          stale      = 1'b0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h8) return 32'hAAAA0013;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [31:0] head_pc();
    return (exp_q.size() > 0) ? exp_q[0].pc : seq_pc;
  endfunction

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc    = seq_pc;
      e.instr = mem_f(seq_pc);
      exp_q.push_back(e);
      seq_pc += 32'd4;
    end
  endtask

  // One clock of stimulus; entered and left at a falling edge.
  task automatic cycle(input bit st, input bit pcs, input logic [31:0] tgt, input bit fl);
    logic [31:0] h;
    imem_bus.rsp_valid = 1'b0;
    if (stale) begin
      imem_bus.rsp_valid = 1'b1;
      imem_bus.rsp_data  = 32'hDEAD0013;
      stale              = 1'b0;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        imem_bus.rsp_valid = 1'b1;
        imem_bus.rsp_data  = mem_f(pend_addr);
        pend               = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_bus.req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (imem_bus.req_valid) begin
      check("one_outstanding", 32'(pend), 32'd0);
      if (imem_bus.req_ready) begin
        check("req_addr", imem_bus.addr, head_pc());
        pend      = 1'b1;
        pend_addr = imem_bus.addr;
        pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end
    if (pcs || fl) begin
      h = head_pc();
      exp_q.delete();
      seq_pc = pcs ? (tgt & ~32'd3) : h;
    end
    refill();
    stall     = st;
    PCSel     = pcs;
    pc_target = tgt;
    IF_flush  = fl;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit with_stale);
    rst_n              = 1'b0;
    stall              = 1'b0;
    PCSel              = 1'b0;
    IF_flush           = 1'b0;
    pc_target          = '0;
    imem_bus.req_ready = 1'b0;
    imem_bus.rsp_valid = 1'b0;
    imem_bus.rsp_data  = '0;
    exp_q.delete();
    seq_pc = RESET_PC;
    pend   = 1'b0;
    refill();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = with_stale;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string name);
    int d0;
    d0 = delivered;
    for (int g = 0; g < 60 && !(delivered > d0 && last_pc == pc); g++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check(name, last_pc, pc);
  endtask

  // Monitor: judges the IF/ID register just after every rising edge.
  initial begin
    logic [31:0] ppc, pin;
    logic        pv;
    exp_t        e;
    ppc = '0; pin = '0; pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'h00000013);
        check("rst_req_valid", 32'(imem_bus.req_valid), 32'd0);
      end else if (PCSel || IF_flush) begin
        check("redirect_kills", 32'(if_valid), 32'd0);
      end else if (stall) begin
        check("stall_valid", 32'(if_valid), 32'(pv));
        check("stall_pc", if_pc, ppc);
        check("stall_instr", if_instr, pin);
      end else if (if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL deliver: unexpected pc %h, expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", if_pc, e.pc);
          check("deliver_instr", if_instr, e.instr);
        end
        delivered++;
        last_pc = if_pc;
      end else begin
        check("bubble_pc", if_pc, ppc);
        check("bubble_instr", if_instr, pin);
      end
      pv  = if_valid;
      ppc = if_pc;
      pin = if_instr;
    end
  end

  initial begin
    bit found;
    int d0;
    do_reset(1'b0);

    // Reset release with a one-cycle memory
    wait_pc(32'h0, "t1_first_pc");
    check("t1_first_instr", if_instr, 32'h00500093);

    // Response for 0x8 lands under a 3-cycle stall
    found = 1'b0;
    for (int g = 0; g < 30 && !found; g++) begin
      if (pend && pend_cnt == 0 && pend_addr == 32'h8) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check("t2_sync", 32'(found), 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("t2_no_req_in_hold", 32'(imem_bus.req_valid), 32'd0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
    end
    check("t2_no_req_in_hold", 32'(imem_bus.req_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_skid_pc", if_pc, 32'h8);
    check("t2_skid_instr", if_instr, 32'hAAAA0013);

    // Branch while waiting on 0x10
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int g = 0; g < 30 && !found; g++) begin
      if (pend && pend_cnt == 1 && pend_addr == 32'h10) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check("t3_sync", 32'(found), 32'd1);
    d0 = delivered;
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    wait_pc(32'h100, "t3_target_pc");
    check("t3_one_delivery", 32'(delivered - d0), 32'd1);

    // Flush together with stall while IF/ID is live
    for (int g = 0; g < 30 && !if_valid; g++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_live_before", 32'(if_valid), 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("t4_flush_beats_stall", 32'(if_valid), 32'd0);

    // PC wrap and target alignment
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_pc(32'hFFFF_FFFC, "t5_top_pc");
    wait_pc(32'h0, "t5_wrap_pc");
    cycle(1'b0, 1'b1, 32'h103, 1'b0);
    wait_pc(32'h100, "t5_aligned_pc");

    // Reset in the middle of an outstanding fetch, stale response afterwards
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int g = 0; g < 30 && !found; g++) begin
      if (pend && pend_cnt == 1) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check("t6_sync", 32'(found), 32'd1);
    do_reset(1'b1);
    check("t6_req_low_at_release", 32'(imem_bus.req_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_req_high", 32'(imem_bus.req_valid), 32'd1);
    check("t6_req_addr", imem_bus.addr, RESET_PC);
    wait_pc(RESET_PC, "t6_reset_pc");
    check("t6_reset_instr", if_instr, mem_f(RESET_PC));

    // Randomized traffic
    rand_ready = 1'b1;
    lat_min = 1; lat_max = 3;
    d0 = delivered;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom, $urandom_range(0, 99) < 3);
      end
    end
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("random_progress", 32'(delivered - d0 > 100), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1);
  end
endmodule
